// File: rtl/serial_adder_nbit_if.sv
// Operand/result bundle for the bit-serial adder.
// Optional signed-overflow flag is present only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_nbit_if #(
    parameter int WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             carry_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             overflow_out;
`endif

    modport master (
        output start_in, a_in, b_in, carry_in,
        input  busy_out, done_out, sum_out, carry_out
`ifdef SERIAL_ADDER_OVF_EN
        , overflow_out
`endif
    );

    modport slave (
        input  start_in, a_in, b_in, carry_in,
        output busy_out, done_out, sum_out, carry_out
`ifdef SERIAL_ADDER_OVF_EN
        , overflow_out
`endif
    );
endinterface

// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder slice per clock, LSB first,
// carry kept in a flop between cycles. Result is registered on completion.
// Optional: define SERIAL_ADDER_OVF_EN to add the signed-overflow flag.
module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    serial_adder_nbit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sr, a_sr_n;
    logic [WIDTH-1:0] b_sr, b_sr_n;
    logic [WIDTH-1:0] sum_sr, sum_sr_n;
    logic             c, c_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sum_q, sum_q_n;
    logic             cout_q, cout_q_n;
    logic             done_q, done_q_n;
    logic             bit_s, bit_c;
    logic [WIDTH-1:0] sum_shifted;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_q_n;
`endif

    // Single full-adder slice on the operand LSBs and the carry flop
    always_comb begin
        bit_s       = a_sr[0] ^ b_sr[0] ^ c;
        bit_c       = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
        sum_shifted = {bit_s, sum_sr[WIDTH-1:1]};
    end

    // Next-state and datapath update
    always_comb begin
        state_n  = state;
        a_sr_n   = a_sr;
        b_sr_n   = b_sr;
        sum_sr_n = sum_sr;
        c_n      = c;
        cnt_n    = cnt;
        sum_q_n  = sum_q;
        cout_q_n = cout_q;
        done_q_n = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_q_n  = ovf_q;
`endif
        case (state)
            IDLE, DONE: begin
                // DONE accepts a start just like IDLE for back-to-back adds
                if (bus.start_in) begin
                    a_sr_n   = bus.a_in;
                    b_sr_n   = bus.b_in;
                    c_n      = bus.carry_in;
                    sum_sr_n = '0;
                    cnt_n    = '0;
                    state_n  = SHIFT;
                end else begin
                    state_n  = IDLE;
                end
            end
            SHIFT: begin
                a_sr_n   = a_sr >> 1;
                b_sr_n   = b_sr >> 1;
                c_n      = bit_c;
                sum_sr_n = sum_shifted;
                cnt_n    = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    sum_q_n  = sum_shifted;
                    cout_q_n = bit_c;
                    done_q_n = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                    // c is still the carry into the MSB at this edge
                    ovf_q_n  = c ^ bit_c;
`endif
                    state_n  = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            a_sr   <= a_sr_n;
            b_sr   <= b_sr_n;
            sum_sr <= sum_sr_n;
            c      <= c_n;
            cnt    <= cnt_n;
            sum_q  <= sum_q_n;
            cout_q <= cout_q_n;
            done_q <= done_q_n;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= ovf_q_n;
`endif
        end
    end

    // Output drive; busy is a direct decode of SHIFT
    always_comb begin
        bus.busy_out  = (state == SHIFT);
        bus.done_out  = done_q;
        bus.sum_out   = sum_q;
        bus.carry_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        bus.overflow_out = ovf_q;
`endif
    end
endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
- Bit-serial N-bit adder that feeds one 1-bit full-adder slice per clock, LSB first, and keeps the carry in a flip-flop between cycles.
- Sits directly around the 1-bit full-adder stage:
  - upstream side: loads the operands and presents one bit pair plus the registered carry each cycle;
  - downstream side: collects the sum bits and the final carry.
- Trades WIDTH cycles of latency for a single adder slice.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk_in  input  1  rising-edge clock
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  request to begin an add; sampled on the rising edge
- a_in  input  WIDTH  operand A, captured when start is accepted
- b_in  input  WIDTH  operand B, captured when start is accepted
- carry_in  input  1  initial carry, captured when start is accepted
- busy_out  output  1  high while bits are being processed
- done_out  output  1  one-cycle pulse when the result is updated
- sum_out  output  WIDTH  registered sum of the last completed add
- carry_out  output  1  registered final carry of the last completed add

Behaviour:
- Clock and reset (fixed): one clock, clk_in; reset is asynchronous and active-low, rst_n_in.
- Reset values:
  - state = IDLE;
  - busy_out = 0, done_out = 0;
  - sum_out = 0, carry_out = 0;
  - internal shift registers, carry flip-flop and bit counter = 0.
- Reset asserted mid-operation: the operation is abandoned immediately. No done_out is produced and sum_out/carry_out clear to 0.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE: start_in = 1 at an edge does all of the following, then the state goes to SHIFT:
  - loads a_in and b_in into the operand shift registers;
  - loads carry_in into the carry flip-flop;
  - clears the bit counter.
- SHIFT: each edge processes bit i, where i is the counter value:
  - s = a[0] ^ b[0] ^ c, computed from the operand register LSBs and the carry flip-flop c;
  - c <= majority(a[0], b[0], c);
  - both operand registers shift right by 1;
  - s shifts into the MSB of the sum shift register;
  - the counter increments.
- SHIFT, edge where counter = WIDTH-1:
  - the last bit is processed;
  - sum_out <= final sum-shift-register contents, including this bit;
  - carry_out <= the final carry;
  - done_out <= 1;
  - state goes to DONE.
- DONE: lasts exactly one cycle with done_out = 1. The next edge returns the state to IDLE and clears done_out.
  - Exception: start_in = 1 in DONE is accepted exactly as in IDLE (back-to-back operation).
- busy_out = 1 exactly while state = SHIFT, i.e. WIDTH consecutive cycles per operation.
- Latency:
  - start accepted at edge k;
  - done_out high in the cycle after edge k+WIDTH;
  - the new result appears in that same cycle.
- sum_out/carry_out hold the previous result throughout SHIFT. They change only at completion or reset.
- start_in while in SHIFT is ignored; operand inputs are don't-care outside the accept edge.
- Counter width is $clog2(WIDTH). Wrap-around of the counter is never observable.
- Result is mod 2^WIDTH, with carry_out as bit WIDTH of a_in + b_in + carry_in.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - adds output port overflow_out (1 bit), reset value 0;
  - captured at completion as (carry into the MSB) XOR (carry out of the MSB), i.e. two's-complement signed overflow;
  - requires the carry before the final bit to be held in one extra flip-flop;
  - holds its value like sum_out.
- Undefined: the port and the extra flop are absent; all other behaviour is identical.

Test Plan:
- Max operand plus one:
  - stimulus: WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulse;
  - response: busy_out high for 8 cycles, then done_out for 1 cycle, sum_out=8'h00, carry_out=1; overflow_out=0 if enabled.
- Carry-in used:
  - stimulus: a=8'h3C, b=8'h5A, cin=1;
  - response: sum_out=8'h97, carry_out=0.
- Signed overflow, with SERIAL_ADDER_OVF_EN defined:
  - stimulus: a=8'h7F, b=8'h01, cin=0;
  - response: sum_out=8'h80, carry_out=0, overflow_out=1.
- Start while busy:
  - stimulus: second start with a=8'h11, b=8'h22 asserted during SHIFT of 8'h3C+8'h5A+1;
  - response: second start ignored, single done_out, sum_out=8'h97.
- Back-to-back and reset:
  - stimulus: start 8'h01+8'h01 in the DONE cycle of a previous add;
  - response: done_out after 8 further cycles, sum_out=8'h02, previous result held until then.
  - stimulus: rst_n_in low in the 4th SHIFT cycle;
  - response: busy_out, done_out, sum_out, carry_out all 0 immediately, state IDLE, no done_out afterwards.
- Random: 1000 random a, b, cin at WIDTH=8 and WIDTH=13, compared against a+b+cin from a reference model.
